// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART transmit arbiter slice.
//   uart_state_t      - arbiter FSM states (IDLE, WAIT_START, WAIT_DONE)
//   UART_NUM_REQ      - default number of requesters sharing the transmitter
//   UART_BUSY_TIMEOUT - default cycles allowed for busy to rise after launch
//   DATA_W            - UART byte width
//   id_width()        - width of a requester index (at least one bit)
package uart_pkg;

  localparam int UART_NUM_REQ      = 4;
  localparam int UART_BUSY_TIMEOUT = 16;
  localparam int DATA_W            = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } uart_state_t;

  // A single requester still needs a one-bit index signal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Uart_Interface: requester bundle and UART transmitter handshake.
//   req[NUM_REQ]          - per-requester request, held until ack
//   req_data[NUM_REQ][8]  - per-requester byte, stable while req high
//   ack[NUM_REQ]          - one-cycle one-hot acceptance pulse
//   transmit              - one-cycle launch pulse to the UART
//   TxData[8]             - byte presented to the UART, held between launches
//   busy                  - UART transmitter busy flag
//   grant_id              - index of the last launched requester
//   tx_error              - one-cycle pulse, busy never rose after a launch
// Modports: master = arbiter side, slave = requesters/UART side.
interface Uart_Interface
  import uart_pkg::*;
#(
  parameter int NUM_REQ = UART_NUM_REQ
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             ack;
  logic                           transmit;
  logic [DATA_W-1:0]              TxData;
  logic                           busy;
  logic [ID_W-1:0]                grant_id;
  logic                           tx_error;

  modport master (
    input  req, req_data, busy,
    output ack, transmit, TxData, grant_id, tx_error
  );

  modport slave (
    output req, req_data, busy,
    input  ack, transmit, TxData, grant_id, tx_error
  );

endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin selector.
//   req[NUM_REQ] - active requests
//   last[ID_W]   - index granted most recently
//   winner[ID_W] - first active request searching upward from last+1,
//                  wrapping NUM_REQ-1 -> 0 (last itself is searched last)
//   valid        - at least one request is active
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  logic [ID_W-1:0] idx;

  // Walk candidates from the farthest to the nearest so the nearest
  // active request is the final assignment and therefore wins.
  always_comb begin
    winner = last;
    valid  = |req;
    idx    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(last) + i) % NUM_REQ);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ requesters.
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - Uart_Interface.master: requests/bytes in, acks out, UART
//           launch (transmit/TxData), busy in, grant_id and tx_error out
// A launch registers transmit, ack[winner], TxData and grant_id together, so
// all of them appear in the cycle after the arbitration edge. The arbiter
// then waits for busy to rise (bounded by BUSY_TIMEOUT) and to fall again
// before it arbitrates once more.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = UART_NUM_REQ,
  parameter int BUSY_TIMEOUT = UART_BUSY_TIMEOUT
) (
  input logic           clk,
  input logic           reset,
  Uart_Interface.master bus
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  uart_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               transmit_q, transmit_d;
  logic               tx_error_q, tx_error_d;

  logic [ID_W-1:0]    pick_id;
  logic               pick_vld;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (bus.req),
    .last   (grant_q),
    .winner (pick_id),
    .valid  (pick_vld)
  );

  // True on the WAIT_START edge that completes the allowed wait.
  function automatic logic timeout_hit(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(BUSY_TIMEOUT - 1);
  endfunction

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    data_d     = data_q;
    ack_d      = '0;
    transmit_d = 1'b0;
    tx_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld && !bus.busy) begin
          transmit_d     = 1'b1;
          ack_d[pick_id] = 1'b1;
          data_d         = bus.req_data[pick_id];
          grant_d        = pick_id;
          cnt_d          = '0;
          state_d        = WAIT_START;
        end
      end

      WAIT_START: begin
        if (bus.busy) begin
          state_d = WAIT_DONE;
        end else if (timeout_hit(cnt_q)) begin
          cnt_d      = CNT_W'(BUSY_TIMEOUT);
          tx_error_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_DONE: begin
        if (!bus.busy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      grant_q    <= ID_W'(NUM_REQ - 1);
      data_q     <= '0;
      ack_q      <= '0;
      transmit_q <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      transmit_q <= transmit_d;
      tx_error_q <= tx_error_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.transmit = transmit_q;
  assign bus.TxData   = data_q;
  assign bus.grant_id = grant_q;
  assign bus.tx_error = tx_error_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: bench for uart_tx_arbiter with a stub UART transmitter,
// requester agents, and a transaction-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;   // 50 MHz

  Uart_Interface #(.NUM_REQ(NR)) bus();

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  localparam int PH_READY = 0, PH_AWAIT_BUSY = 1, PH_AWAIT_IDLE = 2;
  int            m_phase, m_last, m_wait, m_w;
  logic          exp_tx, exp_err;
  logic [NR-1:0] exp_ack;
  logic [7:0]    exp_data;
  logic [1:0]    exp_gid;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = PH_READY; m_last = NR - 1; m_wait = 0;
      exp_tx = 0; exp_ack = '0; exp_data = 8'h00; exp_gid = 2'(NR - 1); exp_err = 0;
    end else begin
      exp_tx = 0; exp_ack = '0; exp_err = 0;
      if (m_phase == PH_READY) begin
        if (bus.req != '0 && !bus.busy) begin
          m_w = -1;
          for (int k = 1; k <= NR; k++)
            if (m_w < 0 && bus.req[(m_last + k) % NR]) m_w = (m_last + k) % NR;
          exp_tx   = 1;
          exp_ack  = NR'(1) << m_w;
          exp_data = bus.req_data[m_w];
          m_last   = m_w;
          exp_gid  = 2'(m_w);
          m_wait   = 0;
          m_phase  = PH_AWAIT_BUSY;
        end
      end else if (m_phase == PH_AWAIT_BUSY) begin
        if (bus.busy) m_phase = PH_AWAIT_IDLE;
        else begin
          m_wait++;
          if (m_wait >= TMO) begin exp_err = 1; m_phase = PH_READY; end
        end
      end else begin
        if (!bus.busy) m_phase = PH_READY;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({bus.transmit, bus.ack, bus.TxData, bus.grant_id, bus.tx_error} !==
          {exp_tx, exp_ack, exp_data, exp_gid, exp_err}) begin
        n_bad++;
        $display("FAIL cycle%0d: dut tx=%b ack=%b data=%h gid=%0d err=%b / model tx=%b ack=%b data=%h gid=%0d err=%b",
                 cyc, bus.transmit, bus.ack, bus.TxData, bus.grant_id, bus.tx_error,
                 exp_tx, exp_ack, exp_data, exp_gid, exp_err);
      end
    end
  end

  // ---------------- agents / logs ----------------
  logic [NR-1:0] hold;
  bit   uart_auto, uart_dead, rnd_mode;
  int   u_dly, u_left, u_len;
  logic [7:0] RxData;
  logic       valid_rx;
  int   n_tx, n_err;
  int   ack_cnt [NR];
  int   launch_id[$];
  int   launch_t[$];
  int   err_t[$];
  logic [7:0] rx_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    n_tx = 0; n_err = 0;
    for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
    launch_id.delete(); launch_t.delete(); err_t.delete(); rx_q.delete();
  endtask

  function automatic int lid(input int k);
    return (k < launch_id.size()) ? launch_id[k] : -1;
  endfunction
  function automatic int lt(input int k);
    return (k < launch_t.size()) ? launch_t[k] : -1000;
  endfunction
  function automatic int et(input int k);
    return (k < err_t.size()) ? err_t[k] : -1000;
  endfunction
  function automatic int rx(input int k);
    return (k < rx_q.size()) ? int'(rx_q[k]) : -1;
  endfunction

  // One clock of bench activity, run at the falling edge.
  task automatic step();
    int r;
    @(negedge clk);
    cyc++;
    valid_rx = 1'b0;
    if (u_dly > 0) begin
      u_dly--;
      if (u_dly == 0) begin bus.busy = 1'b1; u_left = u_len; end
    end else if (u_left > 0) begin
      u_left--;
      if (u_left == 0) bus.busy = 1'b0;
    end
    if (bus.transmit) begin
      n_tx++;
      launch_id.push_back(int'(bus.grant_id));
      launch_t.push_back(cyc);
      RxData = bus.TxData; valid_rx = 1'b1;
      rx_q.push_back(RxData);
      if (uart_auto && !uart_dead) begin
        r = rnd_mode ? int'($urandom_range(0, 9)) : 1;
        if (r == 0)      u_dly = 0;          // UART never answers
        else if (r == 9) u_dly = 18;         // UART answers after the timeout
        else             u_dly = (r % 3) + 1;
        u_len = rnd_mode ? int'($urandom_range(1, 6)) : 4;
      end
    end
    if (bus.tx_error) begin n_err++; err_t.push_back(cyc); end
    for (int i = 0; i < NR; i++)
      if (bus.ack[i]) begin
        ack_cnt[i]++;
        if (!hold[i]) bus.req[i] = 1'b0;
      end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_launches(input string name, input int n, input int limit);
    for (int k = 0; k < limit && launch_id.size() < n; k++) step();
    check(name, int'(launch_id.size() >= n), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic raise(input int i, input logic [7:0] d);
    bus.req_data[i] = d;
    bus.req[i] = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int j;
    reset = 1'b1;
    bus.req = '0; bus.req_data = '0; bus.busy = 1'b0;
    hold = '0; uart_auto = 1; uart_dead = 0; rnd_mode = 0;
    u_dly = 0; u_left = 0; u_len = 4;
    clear_logs();
    step(); step();
    chk_en = 1'b1;

    // Reset state
    check("rst_transmit", int'(bus.transmit), 0);
    check("rst_ack", int'(bus.ack), 0);
    check("rst_tx_error", int'(bus.tx_error), 0);
    check("rst_TxData", int'(bus.TxData), 0);
    check("rst_grant_id", int'(bus.grant_id), 3);
    reset = 1'b0;

    // Single byte "S" from requester 0
    raise(0, 8'h53);
    wait_launches("s_launch", 1, 50);
    run(12);
    check("s_tx_count", n_tx, 1);
    check("s_ack0_count", ack_cnt[0], 1);
    check("s_rxdata", rx(0), 8'h53);
    check("s_txdata_held", int'(bus.TxData), 8'h53);

    // All four requesters after reset: order 0,1,2,3
    reset = 1'b1;
    raise(0, 8'h53); raise(1, 8'h41); raise(2, 8'h55); raise(3, 8'h52);
    step();
    reset = 1'b0;
    clear_logs();
    wait_launches("saur_launch", 4, 200);
    for (int k = 0; k < 4; k++) check($sformatf("saur_id%0d", k), lid(k), k);
    check("saur_rx0", rx(0), 8'h53);
    check("saur_rx1", rx(1), 8'h41);
    check("saur_rx2", rx(2), 8'h55);
    check("saur_rx3", rx(3), 8'h52);
    run(10);

    // Requesters 0 and 2 held continuously
    clear_logs();
    hold[0] = 1; hold[2] = 1;
    raise(0, 8'h10); raise(2, 8'h12);
    wait_launches("alt_launch", 4, 200);
    check("alt_id0", lid(0), 0);
    check("alt_id1", lid(1), 2);
    check("alt_id2", lid(2), 0);
    check("alt_id3", lid(3), 2);
    check("alt_ack1", ack_cnt[1], 0);
    check("alt_ack3", ack_cnt[3], 0);
    hold = '0; bus.req = '0;
    run(15);

    // Busy never rises: timeout then relaunch of requester 2
    do_reset();
    uart_dead = 1;
    raise(1, 8'h31); raise(2, 8'h32);
    wait_launches("to_launch1", 1, 20);
    check("to_first_id", lid(0), 1);
    for (int k = 0; k < 40 && err_t.size() < 1; k++) step();
    check("to_err_delay", et(0) - lt(0), 16);
    wait_launches("to_launch2", 2, 20);
    check("to_second_id", lid(1), 2);
    check("to_relaunch_gap", lt(1) - et(0), 1);
    run(25);
    check("to_err_count", n_err, 2);
    uart_dead = 0;
    run(4);

    // Busy forced high blocks launch; reset during WAIT_DONE
    uart_auto = 0; u_dly = 0; u_left = 0;
    do_reset();
    bus.busy = 1'b1;
    raise(0, 8'h53);
    run(6);
    check("busy_block_tx", n_tx, 0);
    bus.busy = 1'b0;
    step();
    check("busy_release_tx", n_tx, 1);
    bus.busy = 1'b1;
    run(3);
    raise(0, 8'h60); raise(2, 8'h62);
    reset = 1'b1;
    step();
    check("mid_rst_transmit", int'(bus.transmit), 0);
    check("mid_rst_ack", int'(bus.ack), 0);
    check("mid_rst_tx_error", int'(bus.tx_error), 0);
    check("mid_rst_TxData", int'(bus.TxData), 0);
    check("mid_rst_grant_id", int'(bus.grant_id), 3);
    reset = 1'b0; bus.busy = 1'b0;
    clear_logs();
    wait_launches("post_rst_launch", 1, 20);
    check("post_rst_id", lid(0), 0);
    bus.req = '0;
    run(5);

    // Randomized traffic against the model
    uart_auto = 1; rnd_mode = 1; u_dly = 0; u_left = 0; bus.busy = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = ($urandom_range(0, 399) == 0);
      if (c % 200 == 0) hold = NR'($urandom_range(0, (1 << NR) - 1)) & NR'($urandom_range(0, (1 << NR) - 1));
      for (int i = 0; i < NR; i++)
        if (!bus.req[i] && $urandom_range(0, 3) == 0) raise(i, 8'($urandom));
      if ($urandom_range(0, 63) == 0) begin
        j = int'($urandom_range(0, NR - 1));
        bus.req[j] = 1'b0;
      end
    end
    reset = 1'b0; hold = '0; bus.req = '0;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
